// File: rtl/pipe_pkg.sv
// Shared widths and state encoding for the elastic pipeline-stage registers.
package pipe_pkg;
  localparam int XLEN           = 32;
  localparam int DEF_CTRL_W     = 8;
  localparam int DEF_RD_W       = 5;
  localparam int IFID_PAYLOAD_W = 2 * XLEN;
  localparam int IDEX_PAYLOAD_W = 4 * XLEN;
  localparam int EXMA_PAYLOAD_W = 2 + 5 * XLEN;
  localparam int MAWB_PAYLOAD_W = 2 * XLEN;
  localparam int DEF_PAYLOAD_W  = 3 + 5 * XLEN;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle for pipe_stage_skid.
// PIPE_STAGE_STALL_CNT_EN adds the stallCntOut observation port.
interface pipe_stage_skid_if import pipe_pkg::*; #(
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int RD_W      = DEF_RD_W
);
  logic                 flushIn;
  logic                 validIn;
  logic                 readyOut;
  logic [CTRL_W-1:0]    ctrSignalsIn;
  logic [PAYLOAD_W-1:0] payloadIn;
  logic [RD_W-1:0]      rdIn;
  logic                 validOut;
  logic                 readyIn;
  logic [CTRL_W-1:0]    ctrSignalsOut;
  logic [PAYLOAD_W-1:0] payloadOut;
  logic [RD_W-1:0]      rdOut;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0]          stallCntOut;
`endif

  modport master (
    output flushIn, validIn, ctrSignalsIn, payloadIn, rdIn, readyIn,
    input  readyOut, validOut, ctrSignalsOut, payloadOut, rdOut
`ifdef PIPE_STAGE_STALL_CNT_EN
    , input stallCntOut
`endif
  );

  modport slave (
    input  flushIn, validIn, ctrSignalsIn, payloadIn, rdIn, readyIn,
    output readyOut, validOut, ctrSignalsOut, payloadOut, rdOut
`ifdef PIPE_STAGE_STALL_CNT_EN
    , output stallCntOut
`endif
  );
endinterface

// File: rtl/pipe_entry.sv
// One valid-tagged stage entry; ctrl/rd read back as zero whenever the entry is empty.
module pipe_entry #(
  parameter int CW = 8,
  parameter int PW = 163,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] ctrl_d,
  input  logic [PW-1:0] pay_d,
  input  logic [RW-1:0] rd_d,
  output logic          vld,
  output logic [CW-1:0] ctrl_q,
  output logic [PW-1:0] pay_q,
  output logic [RW-1:0] rd_q
);
  logic [CW-1:0] ctrl_r;
  logic [RW-1:0] rd_r;

  // Payload is left untouched on clear so it stays stable through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= 1'b0;
      ctrl_r <= '0;
      pay_q  <= '0;
      rd_r   <= '0;
    end else if (clear) begin
      vld    <= 1'b0;
      ctrl_r <= '0;
      rd_r   <= '0;
    end else if (load) begin
      vld    <= 1'b1;
      ctrl_r <= ctrl_d;
      pay_q  <= pay_d;
      rd_r   <= rd_d;
    end
  end

  assign ctrl_q = vld ? ctrl_r : '0;
  assign rd_q   = vld ? rd_r   : '0;
endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage register: main entry M drives the outputs, skid entry S absorbs one
// extra item so readyOut comes straight from a flop. PIPE_STAGE_STALL_CNT_EN adds stallCntOut.
module pipe_stage_skid import pipe_pkg::*; #(
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int RD_W      = DEF_RD_W
) (
  input logic              clkIn,
  input logic              resetIn,
  pipe_stage_skid_if.slave bus
);
  logic                 m_vld, s_vld, accept;
  logic                 m_load, m_clear, s_load, s_clear, m_from_s;
  logic [CTRL_W-1:0]    s_ctrl, m_ctrl_d;
  logic [PAYLOAD_W-1:0] s_pay, m_pay_d;
  logic [RD_W-1:0]      s_rd, m_rd_d;
  state_e               state;

  assign bus.readyOut = ~s_vld;
  assign bus.validOut = m_vld;
  assign accept       = bus.validIn & ~s_vld;

  always_comb begin
    state = m_vld ? (s_vld ? FULL : ONE) : EMPTY;
  end

  // Flush wins over everything and blocks a concurrent accept.
  always_comb begin
    m_load   = 1'b0;
    m_clear  = bus.flushIn;
    s_load   = 1'b0;
    s_clear  = bus.flushIn;
    m_from_s = 1'b0;
    if (!bus.flushIn) begin
      unique case (state)
        EMPTY: m_load = accept;
        ONE: begin
          if (accept) begin
            if (bus.readyIn) m_load = 1'b1;
            else             s_load = 1'b1;
          end else if (bus.readyIn) begin
            m_clear = 1'b1;
          end
        end
        FULL: begin
          if (bus.readyIn) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clear  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_ctrl_d = m_from_s ? s_ctrl : bus.ctrSignalsIn;
  assign m_pay_d  = m_from_s ? s_pay  : bus.payloadIn;
  assign m_rd_d   = m_from_s ? s_rd   : bus.rdIn;

  pipe_entry #(.CW(CTRL_W), .PW(PAYLOAD_W), .RW(RD_W)) u_main (
    .clk(clkIn), .rst(resetIn), .clear(m_clear), .load(m_load),
    .ctrl_d(m_ctrl_d), .pay_d(m_pay_d), .rd_d(m_rd_d),
    .vld(m_vld), .ctrl_q(bus.ctrSignalsOut), .pay_q(bus.payloadOut), .rd_q(bus.rdOut)
  );

  pipe_entry #(.CW(CTRL_W), .PW(PAYLOAD_W), .RW(RD_W)) u_skid (
    .clk(clkIn), .rst(resetIn), .clear(s_clear), .load(s_load),
    .ctrl_d(bus.ctrSignalsIn), .pay_d(bus.payloadIn), .rd_d(bus.rdIn),
    .vld(s_vld), .ctrl_q(s_ctrl), .pay_q(s_pay), .rd_q(s_rd)
  );

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn)                                      stall_cnt <= '0;
    else if (m_vld && !bus.readyIn && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stallCntOut = stall_cnt;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + randomized bench for pipe_stage_skid against a depth-2 FIFO reference model.
module tb_pipe_stage_skid;
  localparam int CW = 8;
  localparam int PW = 163;
  localparam int RW = 5;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [PW-1:0] p;
    logic [RW-1:0] r;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(CW), .PAYLOAD_W(PW), .RD_W(RW)) bus();
  pipe_stage_skid #(.CTRL_W(CW), .PAYLOAD_W(PW), .RD_W(RW)) dut (
    .clkIn(clk), .resetIn(rst), .bus(bus)
  );

  ent_t          q[$];
  int unsigned   stall_m = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  logic [PW-1:0] prev_pay;
  bit            have_prev = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ent_t mk(input int i);
    ent_t e;
    e.c = CW'(i);
    e.p = PW'(i);
    e.r = RW'(i);
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    e.c = CW'($urandom());
    e.p = w[PW-1:0];
    e.r = RW'($urandom());
    return e;
  endfunction

  task automatic drive(input logic v, input logic r, input logic f, input ent_t e);
    bus.validIn      = v;
    bus.readyIn      = r;
    bus.flushIn      = f;
    bus.ctrSignalsIn = e.c;
    bus.payloadIn    = e.p;
    bus.rdIn         = e.r;
  endtask

  task automatic check_all();
    chk("validOut", bus.validOut, q.size() > 0);
    chk("readyOut", bus.readyOut, q.size() < 2);
    chk("ctrSignalsOut", bus.ctrSignalsOut, q.size() > 0 ? q[0].c : '0);
    chk("rdOut", bus.rdOut, q.size() > 0 ? q[0].r : '0);
    if (q.size() > 0) chk("payloadOut", bus.payloadOut, q[0].p);
    else if (have_prev) chk("payload_stable", bus.payloadOut, prev_pay);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stallCntOut", bus.stallCntOut, stall_m);
`endif
    prev_pay  = bus.payloadOut;
    have_prev = 1;
  endtask

  // One clock: the model is a 2-deep FIFO; readyOut means "room left", validOut means "not empty".
  task automatic step();
    ent_t e_in;
    bit push, pop;
    @(posedge clk);
    e_in = {bus.ctrSignalsIn, bus.payloadIn, bus.rdIn};
    if (rst) begin
      q.delete();
      stall_m = 0;
    end else begin
      if (q.size() > 0 && !bus.readyIn && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (bus.flushIn) q.delete();
      else begin
        push = bus.validIn && q.size() < 2;
        pop  = q.size() > 0 && bus.readyIn;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e_in);
      end
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("rst_validOut", bus.validOut, 1'b0);
    chk("rst_readyOut", bus.readyOut, 1'b1);
    chk("rst_ctrl", bus.ctrSignalsOut, '0);
    chk("rst_rd", bus.rdOut, '0);
    chk("rst_payload", bus.payloadOut, '0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("rst_stallCnt", bus.stallCntOut, '0);
`endif
    q.delete();
    stall_m   = 0;
    prev_pay  = '0;
    have_prev = 1;
  endtask

  initial begin
    ent_t z, a, b, c;
    z = '0;
    a = rand_ent();
    b = rand_ent();
    c = rand_ent();
    drive(1'b0, 1'b0, 1'b0, z);
    #1;
    async_reset();
    step();
    rst = 1'b0;

    // Async reset mid-transfer with the stage full and validIn still high
    drive(1'b1, 1'b0, 1'b0, a); step();
    drive(1'b1, 1'b0, 1'b0, b); step();
    #3;
    async_reset();
    step();
    drive(1'b0, 1'b0, 1'b0, z);
    rst = 1'b0;
    step();

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, mk(i));
      step();
      chk("stream_payload", bus.payloadOut, i);
      chk("stream_ready", bus.readyOut, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0, z); step();
    chk("stream_drained", bus.validOut, 1'b0);

    // Backpressure: fill both entries, then release
    drive(1'b1, 1'b0, 1'b0, a); step();
    drive(1'b1, 1'b0, 1'b0, b); step();
    chk("bp_ready_low", bus.readyOut, 1'b0);
    chk("bp_hold_a", bus.payloadOut, a.p);
    drive(1'b0, 1'b0, 1'b0, z); step();
    chk("bp_still_a", bus.payloadOut, a.p);
    drive(1'b0, 1'b1, 1'b0, z); step();
    chk("bp_then_b", bus.payloadOut, b.p);
    chk("bp_ready_back", bus.readyOut, 1'b1);
    step();
    chk("bp_empty", bus.validOut, 1'b0);

    // Flush while FULL with C offered, and while ONE with C acceptable
    drive(1'b1, 1'b0, 1'b0, a); step();
    drive(1'b1, 1'b0, 1'b0, b); step();
    drive(1'b1, 1'b0, 1'b1, c); step();
    chk("flush_full_valid", bus.validOut, 1'b0);
    chk("flush_full_ctrl", bus.ctrSignalsOut, '0);
    chk("flush_full_rd", bus.rdOut, '0);
    chk("flush_full_ready", bus.readyOut, 1'b1);
    drive(1'b0, 1'b1, 1'b0, z); step(); step();
    chk("flush_no_c", bus.validOut, 1'b0);
    drive(1'b1, 1'b0, 1'b0, a); step();
    drive(1'b1, 1'b1, 1'b1, c); step();
    chk("flush_one_drops_c", bus.validOut, 1'b0);
    drive(1'b0, 1'b1, 1'b0, z); step();

`ifdef PIPE_STAGE_STALL_CNT_EN
    async_reset();
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, a); step();
    drive(1'b0, 1'b0, 1'b0, z);
    repeat (5) step();
    chk("stall_five", bus.stallCntOut, 32'd5);
    drive(1'b0, 1'b1, 1'b1, z); step();
    chk("stall_after_flush", bus.stallCntOut, 32'd5);
    drive(1'b0, 1'b1, 1'b0, z); step();
    chk("stall_kept", bus.stallCntOut, 32'd5);
`endif

    // Randomized traffic with occasional flushes
    for (int k = 0; k < 1000; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0, rand_ent());
      step();
    end
    drive(1'b0, 1'b1, 1'b0, z);
    repeat (3) step();
    chk("final_empty", bus.validOut, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, elastic pipeline-stage register that generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block.
- Carries a control field, a generic packed payload and a destination-register field.
- Uses a valid/ready handshake with a 2-entry skid buffer, so stalls propagate upstream without a combinational ready path.
- Flush kills the held contents and inserts bubbles.

Parameters:
CTRL_W, 8, width of control-signal field; zeroed for bubbles
PAYLOAD_W, 163, width of packed data payload (e.g. Less, Zero, Result, Data, Imm32, PCRelAddr, retAddr)
RD_W, 5, destination-register index width

Ports:
clkIn  input  1  clock, rising edge
resetIn  input  1  reset; asynchronous and active-high
flushIn  input  1  synchronous flush from hazard/branch unit
validIn  input  1  upstream stage presents an instruction
readyOut  output  1  stage can accept; registered
ctrSignalsIn  input  CTRL_W  control field in
payloadIn  input  PAYLOAD_W  data payload in
rdIn  input  RD_W  destination register in
validOut  output  1  output entry holds a live instruction
readyIn  input  1  downstream accepts this cycle
ctrSignalsOut  output  CTRL_W  control field out; 0 when validOut=0
payloadOut  output  PAYLOAD_W  payload out
rdOut  output  RD_W  destination out; 0 when validOut=0

Behaviour:
- Storage: main entry M (drives the outputs) and skid entry S, each with its own valid bit.
- States: EMPTY (M, S invalid), ONE (M valid), FULL (M and S valid).
- readyOut = ~S.valid, registered. Upstream transfers on validIn & readyOut; downstream transfers on validOut & readyIn.
- Reset (async, resetIn=1): all valids 0; ctrSignalsOut, payloadOut, rdOut = 0; readyOut = 1.
  - Reset asserted mid-transfer drops the in-flight data.
  - First acceptance happens on the first rising edge after deassertion.
- Latency: 1 cycle from accept to validOut when the stage is EMPTY, or when in ONE with readyIn=1.
- EMPTY + accept -> ONE; M loads input.
- ONE:
  - accept & readyIn -> ONE; M loads input (full throughput).
  - accept & ~readyIn -> FULL; S loads input.
  - ~accept & readyIn -> EMPTY.
- FULL (readyOut=0, no accept):
  - readyIn -> ONE; M <= S.
  - ~readyIn -> hold both entries.
- Flush has highest priority after reset:
  - M and S valid bits cleared; ctr/rd fields zeroed.
  - A concurrent validIn is NOT captured.
  - Next cycle: readyOut=1, validOut=0.
- Bubble rule: whenever validOut=0, ctrSignalsOut=0 and rdOut=0, so no writes or forwarding occur downstream. payloadOut is don't-care but must be stable.
- Data ordering is strictly FIFO; no duplication or loss under any readyIn pattern.
- Outputs are registered only; there are no combinational paths from input to output.

Optional Feature:
Macro PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - Adds output stallCntOut[31:0]: saturating count of cycles with validOut & ~readyIn.
  - Reset to 0 by resetIn; unaffected by flushIn.
  - Sticks at 0xFFFFFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - default widths CTRL_W=8, RD_W=5, XLEN=32.
  - per-stage payload widths, e.g. EXMA_PAYLOAD_W = 2 + 5*XLEN.
  - state encoding typedef (EMPTY/ONE/FULL).
- One natural sub-module, pipe_entry: a single valid-tagged register with load/clear and a bubble-zeroing output mux. It is instantiated twice (M, S).

Test Plan:
- Reset: resetIn=1 asynchronously between edges -> validOut=0, readyOut=1, ctrSignalsOut=0, rdOut=0 immediately.
- Streaming: readyIn=1, validIn=1 with payloads 1..8 on consecutive cycles -> outputs 1..8 one cycle later, one per cycle, readyOut stays 1.
- Backpressure:
  - Accept A, B while readyIn=0 -> readyOut falls to 0 after B; validOut=1 holding A.
  - Raise readyIn -> A then B emitted, readyOut returns to 1.
- Flush in FULL, with validIn=1 carrying C -> next cycle validOut=0, ctrSignalsOut=0, rdOut=0, readyOut=1; C never appears.
- Randomised readyIn/validIn, 1000 cycles, scoreboard -> exact in-order delivery, no loss or duplication.
- With PIPE_STAGE_STALL_CNT_EN: hold validOut=1, readyIn=0 for 5 cycles -> stallCntOut=5; flush -> stays 5.
